// File: rtl/serial_add_pkg.sv
// Shared types and width helpers for the serial adder scheduler.
// Imported by the interface, the datapath core and the scheduler top.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_NUM_REQ   = 4;

    // Requester-ID width; never below one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit-counter width, able to hold DATAWIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Request/response bundle between requesters, consumer and scheduler.
// master = requesters plus consumer side, slave = scheduler side.
interface serial_add_sched_if
    import serial_add_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ*DATAWIDTH-1:0] i_req_a;
    logic [NUM_REQ*DATAWIDTH-1:0] i_req_b;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic                         o_rsp_valid;
    logic                         i_rsp_ready;
    logic [DATAWIDTH-1:0]         o_rsp_sum;
    logic                         o_rsp_cout;
    logic [ID_W-1:0]              o_rsp_id;
    logic                         o_busy;

    modport master (
        output i_req_valid,
        output i_req_a,
        output i_req_b,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_sum,
        input  o_rsp_cout,
        input  o_rsp_id,
        input  o_busy
    );

    modport slave (
        input  i_req_valid,
        input  i_req_a,
        input  i_req_b,
        input  i_rsp_ready,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_sum,
        output o_rsp_cout,
        output o_rsp_id,
        output o_busy
    );

endinterface

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: operand shifters, full adder, carry, sum.
// Purely driven by load/shift strobes; sequencing lives in the scheduler.
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATAWIDTH-1:0] a_in,
    input  logic [DATAWIDTH-1:0] b_in,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 cout
);

    logic [DATAWIDTH-1:0] a_sr;
    logic [DATAWIDTH-1:0] b_sr;
    logic [DATAWIDTH-1:0] sum_sr;
    logic                 carry;
    logic                 s_bit;
    logic                 c_next;

    assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    // Operand registers: parallel load, then shift right to expose the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
        end else if (load) begin
            a_sr <= a_in;
            b_sr <= b_in;
        end else if (shift) begin
            a_sr <= {1'b0, a_sr[DATAWIDTH-1:1]};
            b_sr <= {1'b0, b_sr[DATAWIDTH-1:1]};
        end
    end

    // Carry flop: cleared on load, ripples one bit per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= 1'b0;
        end else if (shift) begin
            carry <= c_next;
        end
    end

    // Sum register: sum bits enter at the MSB so LSB lands at bit 0 last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sr <= '0;
        end else if (load) begin
            sum_sr <= '0;
        end else if (shift) begin
            sum_sr <= {s_bit, sum_sr[DATAWIDTH-1:1]};
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder among requesters.
// Grants in IDLE, shifts DATAWIDTH bit-cycles, then holds the response.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ
) (
    input  logic              i_clk,
    input  logic              i_rst,
    serial_add_sched_if.slave bus
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = cnt_w(DATAWIDTH);

    state_t               state;
    state_t               state_nx;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      win_id;
    logic                 win_any;
    logic [NUM_REQ-1:0]   grant;
    logic [CNT_W-1:0]     cnt;
    logic                 load;
    logic                 shift;
    logic [ID_W-1:0]      ptr_nx;
    logic [DATAWIDTH-1:0] a_sel;
    logic [DATAWIDTH-1:0] b_sel;

    // Round-robin pick: the lowest offset from rr_ptr with valid set wins.
    always_comb begin
        int idx;
        logic [ID_W-1:0] cand;
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (bus.i_req_valid[cand]) begin
                win_any = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Winner's operands routed to the core load port.
    always_comb begin
        a_sel = bus.i_req_a[win_id*DATAWIDTH +: DATAWIDTH];
        b_sel = bus.i_req_b[win_id*DATAWIDTH +: DATAWIDTH];
    end

    // Next-state and strobe decode for the three-state sequencer.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        grant    = '0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    grant[win_id] = 1'b1;
                    load          = 1'b1;
                    state_nx      = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt == CNT_W'(DATAWIDTH - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.i_rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bit counter: zeroed on load, counts completed bit-cycles.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Latch the served requester for the response.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            id_q <= '0;
        end else if (load) begin
            id_q <= win_id;
        end
    end

    assign ptr_nx = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    // Pointer moves past the served requester once its result is taken.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_ptr <= '0;
        end else if (state == DONE && bus.i_rsp_ready) begin
            rr_ptr <= ptr_nx;
        end
    end

    serial_add_core #(
        .DATAWIDTH (DATAWIDTH)
    ) u_core (
        .clk   (i_clk),
        .rst_n (i_rst),
        .load  (load),
        .shift (shift),
        .a_in  (a_sel),
        .b_in  (b_sel),
        .sum   (bus.o_rsp_sum),
        .cout  (bus.o_rsp_cout)
    );

    assign bus.o_req_ready = grant;
    assign bus.o_rsp_valid = (state == DONE);
    assign bus.o_rsp_id    = id_q;
    assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched: directed and random traffic.
// A monitor predicts grants and results from plain arithmetic.
module tb_serial_add_sched;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    serial_add_sched_if #(.DATAWIDTH(W), .NUM_REQ(N)) bus();

    serial_add_sched #(.DATAWIDTH(W), .NUM_REQ(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N-1:0] vld;
    logic [W-1:0] a_arr [N];
    logic [W-1:0] b_arr [N];

    exp_t sb [$];
    int   gq [$];
    int   gcq [$];
    int   last_g = 0;
    int   ptr_m = 0;
    bit   idle_m = 1'b1;
    bit   hold = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic [1:0]   h_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reference arbiter, scoreboard push on grant, pop on response.
    always @(negedge clk) begin
        logic [N-1:0] er;
        logic [W:0]   t;
        logic [W-1:0] ka;
        logic [W-1:0] kb;
        exp_t         e;
        int           w;
        if (!rst) begin
            sb.delete();
            idle_m = 1'b1;
            ptr_m  = 0;
            hold   = 1'b0;
        end else begin
            er = '0;
            if (idle_m) begin
                for (int i = N - 1; i >= 0; i--) begin
                    w = (ptr_m + i) % N;
                    if (bus.i_req_valid[w]) begin
                        er = '0;
                        er[w] = 1'b1;
                    end
                end
            end
            chk("req_ready", bus.o_req_ready, er);
            chk("busy", bus.o_busy, !idle_m);
            for (int k = 0; k < N; k++) begin
                if (bus.o_req_ready[k]) begin
                    ka = bus.i_req_a[k*W +: W];
                    kb = bus.i_req_b[k*W +: W];
                    t = {1'b0, ka} + {1'b0, kb};
                    e.s = t[W-1:0];
                    e.c = t[W];
                    e.id = k;
                    sb.push_back(e);
                    gq.push_back(k);
                    gcq.push_back(cyc);
                    last_g = cyc;
                    idle_m = 1'b0;
                end
            end
            if (bus.o_rsp_valid) begin
                if (!hold) begin
                    chk("latency", cyc, last_g + W + 1);
                end else begin
                    chk("hold_sum", bus.o_rsp_sum, h_sum);
                    chk("hold_cout", bus.o_rsp_cout, h_cout);
                    chk("hold_id", bus.o_rsp_id, h_id);
                end
                if (bus.i_rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rsp actual=valid required=none at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_sum", bus.o_rsp_sum, e.s);
                        chk("rsp_cout", bus.o_rsp_cout, e.c);
                        chk("rsp_id", bus.o_rsp_id, e.id);
                        ptr_m  = (e.id + 1) % N;
                        idle_m = 1'b1;
                    end
                    hold = 1'b0;
                end else begin
                    hold   = 1'b1;
                    h_sum  = bus.o_rsp_sum;
                    h_cout = bus.o_rsp_cout;
                    h_id   = bus.o_rsp_id;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic apply();
        bus.i_req_valid = vld;
        for (int k = 0; k < N; k++) begin
            bus.i_req_a[k*W +: W] = a_arr[k];
            bus.i_req_b[k*W +: W] = b_arr[k];
        end
    endtask

    task automatic tick();
        logic [N-1:0] g;
        @(negedge clk);
        g = bus.o_req_ready & bus.i_req_valid;
        @(posedge clk);
        #1;
        vld = vld & ~g;
        apply();
    endtask

    task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        a_arr[k] = a;
        b_arr[k] = b;
        vld[k]   = 1'b1;
        apply();
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (vld == '0 && !bus.o_busy && !bus.o_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=busy required=idle at cycle %0d", cyc);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        vld = '0;
        apply();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, bus.o_req_ready, 0);
        chk({tag, "_valid"}, bus.o_rsp_valid, 0);
        chk({tag, "_sum"}, bus.o_rsp_sum, 0);
        chk({tag, "_cout"}, bus.o_rsp_cout, 0);
        chk({tag, "_id"}, bus.o_rsp_id, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
    endtask

    initial begin
        int n;
        bit seen;
        vld = '0;
        for (int k = 0; k < N; k++) begin
            a_arr[k] = '0;
            b_arr[k] = '0;
        end
        bus.i_rsp_ready = 1'b0;
        apply();
        #12;
        chk_zero("reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();

        // Single op and overflow cases
        bus.i_rsp_ready = 1'b1;
        send(0, 8'h5A, 8'h3C);
        drain();
        send(2, 8'hFF, 8'h01);
        drain();
        send(2, 8'h80, 8'h80);
        drain();

        // Fairness: pointer sits past id 2, so 3 goes before 1
        n = gq.size();
        send(1, 8'h11, 8'h22);
        send(3, 8'hF0, 8'h20);
        drain();
        chk("rr_first", gq[n], 3);
        chk("rr_second", gq[n+1], 1);

        // Contention from reset: pointer order, one op per W+2 cycles
        pulse_reset();
        n = gq.size();
        send(0, 8'h01, 8'h02);
        send(1, 8'h7F, 8'h81);
        send(2, 8'hAA, 8'h55);
        send(3, 8'hC3, 8'h4E);
        drain();
        for (int i = 0; i < N; i++) begin
            chk("cont_order", gq[n+i], i);
            if (i > 0) begin
                chk("cont_spacing", gcq[n+i] - gcq[n+i-1], W + 2);
            end
        end

        // Backpressure with requester 1 waiting
        bus.i_rsp_ready = 1'b0;
        n = gq.size();
        send(0, 8'h39, 8'hC8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_reached_done", seen, 1);
        send(1, 8'h64, 8'h64);
        repeat (5) tick();
        chk("bp_valid_held", bus.o_rsp_valid, 1);
        chk("bp_no_grant", bus.o_req_ready, 0);
        bus.i_rsp_ready = 1'b1;
        drain();
        chk("bp_first", gq[n], 0);
        chk("bp_second", gq[n+1], 1);

        // Reset at SHIFT bit-cycle 4
        send(3, 8'hDE, 8'hAD);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_started", seen, 1);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        vld = '0;
        apply();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (12) tick();
        n = gq.size();
        send(2, 8'h9C, 8'h9C);
        drain();
        chk("post_rst_grant", gq[n], 2);

        // Random traffic with random consumer backpressure
        for (int c = 0; c < 500; c++) begin
            tick();
            bus.i_rsp_ready = ($urandom_range(2) != 0);
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && $urandom_range(3) == 0) begin
                    send(k, 8'($urandom), 8'($urandom));
                end
            end
        end
        bus.i_rsp_ready = 1'b1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Round-robin scheduler that shares one bit-serial adder datapath among `NUM_REQ` requesters. Each requester presents two `DATAWIDTH`-bit operands with a valid/ready handshake. The block grants one requester, sequences the load and shift of the serial datapath for exactly `DATAWIDTH` bit-cycles, and returns the sum, carry-out and requester ID through a response handshake. It sits between the request-generating logic and the serial adder core, replacing ad-hoc per-user counters.

## Interface
- `DATAWIDTH`, 8 — operand/sum width in bits; ≥ 2.
- `NUM_REQ`, 4 — number of requesters; ≥ 2.
- `i_clk`  in  1  — single clock, all state on the rising edge.
- `i_rst`  in  1  — reset, asynchronous, active-low.
- `i_req_valid`  in  `NUM_REQ`  — per-requester request valid.
- `i_req_a`  in  `NUM_REQ*DATAWIDTH`  — operand A; requester k occupies slice [k*DATAWIDTH +: DATAWIDTH].
- `i_req_b`  in  `NUM_REQ*DATAWIDTH`  — operand B; same packing as `i_req_a`.
- `o_req_ready`  out  `NUM_REQ`  — one-hot grant, combinational; at most one bit high.
- `o_rsp_valid`  out  1  — result available.
- `i_rsp_ready`  in  1  — consumer accepts the result.
- `o_rsp_sum`  out  `DATAWIDTH`  — (A+B) mod 2^DATAWIDTH.
- `o_rsp_cout`  out  1  — final carry-out.
- `o_rsp_id`  out  `$clog2(NUM_REQ)`  — index of the served requester.
- `o_busy`  out  1  — high in any state other than IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If any `i_req_valid` is high, pick the winner by round-robin. Search starts at pointer `rr_ptr` and wraps modulo `NUM_REQ`.
  - Drive `o_req_ready[winner]=1` in the same cycle; the handshake completes in that cycle.
  - On the next edge: capture A and B of the winner into core shift registers, clear the carry flop and bit counter, latch the winner ID, go to SHIFT.
  - If no request is valid: `o_req_ready` is all zero and the FSM stays in IDLE.
- **SHIFT**
  - Each cycle: full-add A[0], B[0] and the carry flop; shift the sum bit into the MSB of the sum register (LSB-first result assembly); shift A and B right by one; update the carry flop; increment the bit counter.
  - After the `DATAWIDTH`-th bit-cycle, go to DONE. The sum register then holds the full result and the carry flop holds the carry-out.
  - `o_req_ready` is all zero.
- **DONE**
  - `o_rsp_valid=1`; sum, cout and ID are held stable.
  - When `i_rsp_ready=1`: go to IDLE on that edge and set `rr_ptr` to (granted ID + 1) mod `NUM_REQ`.
  - When `i_rsp_ready=0`: stay in DONE. No new grant is issued (single outstanding operation).
- Requester rules:
  - A requester must hold valid and operands stable until it sees ready.
  - Dropping valid in IDLE before grant is legal; that requester is simply not selected.
  - Requests arriving during SHIFT or DONE wait; they are not lost.
- Width: the carry chain is exactly `DATAWIDTH` bits. Overflow appears only on `o_rsp_cout`.

## Timing
- Handshake accepted at edge t.
- SHIFT occupies cycles t+1 … t+`DATAWIDTH`.
- `o_rsp_valid` rises at t+`DATAWIDTH`+1.
- With `i_rsp_ready` tied high, the next grant is possible at cycle t+`DATAWIDTH`+2, giving a peak throughput of one op per `DATAWIDTH`+2 cycles.
- Reset (`i_rst`=0, asynchronous):
  - State → IDLE; `rr_ptr`, bit counter, carry, ID and sum register → 0.
  - Outputs: `o_req_ready`=0, `o_rsp_valid`=0, `o_rsp_sum`=0, `o_rsp_cout`=0, `o_rsp_id`=0, `o_busy`=0.
- Reset asserted mid-SHIFT or mid-DONE discards the operation; no response is ever produced for it.
- First grant after reset deassertion is possible in the first IDLE cycle.
- Simultaneous requests from all inputs are served in pointer order, one at a time. No requester waits more than `NUM_REQ`−1 other operations.

## Structure
- Shared package `serial_add_pkg` holds:
  - state enum (IDLE, SHIFT, DONE);
  - localparam helpers for `$clog2(NUM_REQ)` and the bit-counter width `$clog2(DATAWIDTH+1)`.
- One sub-module: `serial_add_core`, the datapath. It contains:
  - two operand shift registers with load/shift enables;
  - the full-adder expression;
  - the carry flop with synchronous clear on load;
  - the sum shift register.
- The scheduler owns the FSM, round-robin pointer, bit counter, ID latch and handshakes. `serial_add_core` has no control logic of its own.

## Test plan
- **Single op:** requester 0 sends A=8'h5A, B=8'h3C at t. Expect `o_req_ready`=4'b0001 at t; `o_rsp_valid` at t+9 with sum 8'h96, cout 0, id 0.
- **Overflow:** requester 2 sends A=8'hFF, B=8'h01. Expect sum 8'h00, cout 1, id 2. Also A=8'h80, B=8'h80 → sum 8'h00, cout 1.
- **Contention:** all four valid from reset with distinct operands, `i_rsp_ready`=1. Expect grants 0,1,2,3 spaced 10 cycles apart, each response matching its operands and ID.
- **Round-robin fairness:** after serving id 2, requesters 1 and 3 both valid. Expect grant 3, then grant 1.
- **Backpressure:** hold `i_rsp_ready`=0 for 5 cycles in DONE while requester 1 is valid. Expect `o_rsp_valid` held, outputs stable, `o_req_ready`=0; grant to requester 1 only after the response is accepted.
- **Reset mid-op:** assert `i_rst` at SHIFT bit-cycle 4. Expect all outputs 0 immediately (asynchronous), no response for the dropped op, and correct service of a fresh request after release.
